// File: rtl/dac_ramp_ctrl_if.sv
// Write-request handshake between the ramp sequencer and the DAC8531 SPI engine.
// OVER is the engine's idle/done flag: 1 = idle, 0 = transfer in progress.
interface dac_ramp_ctrl_if;
   logic        TR;
   logic [23:0] DATA;
   logic        OVER;

   modport master (output TR, output DATA, input OVER);
   modport slave  (input TR, input DATA, output OVER);
endinterface

// File: rtl/dac_ramp_ctrl.sv
// Slews the DAC8531 code toward a requested target in bounded steps, one SPI write
// per step, with a settle gap between writes and a sticky timeout on a stalled engine.
module dac_ramp_ctrl #(
   parameter int unsigned MAX_STEP    = 256,
   parameter int unsigned HOLD_CYC    = 1000,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter logic [15:0] INIT_CODE   = 16'h8000,
   parameter logic [1:0]  PD_MODE     = 2'b00
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            TGT_VALID,
   input  logic [15:0]     TGT_CODE,
   input  logic            CLR_ERR,
   dac_ramp_ctrl_if.master spi,
   output logic [15:0]     CUR_CODE,
   output logic            BUSY,
   output logic            AT_TARGET,
   output logic            ERR_TIMEOUT
);
   localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
   localparam int          HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [15:0] STEP_LIM  = 16'(MAX_STEP);
   localparam logic [23:0] INIT_WORD = {6'b0, PD_MODE, INIT_CODE};

   typedef enum logic [2:0] {S_IDLE, S_STEP, S_REQ, S_XFER, S_HOLD, S_FAULT} state_t;

   state_t        state, state_nxt;
   logic [15:0]   tgt, next_code, up_dist, dn_dist;
   logic [23:0]   data_q;
   logic          tr_q, dirty, tmo_hit, hold_done;
   logic [TW-1:0] tmo_cnt;
   logic [HW-1:0] hold_cnt;

   // Step toward the target; the clamp never exceeds the distance, so no wrap.
   always_comb begin
      up_dist   = tgt - CUR_CODE;
      dn_dist   = CUR_CODE - tgt;
      next_code = CUR_CODE;
      if (tgt > CUR_CODE)
         next_code = CUR_CODE + ((up_dist > STEP_LIM) ? STEP_LIM : up_dist);
      else if (tgt < CUR_CODE)
         next_code = CUR_CODE - ((dn_dist > STEP_LIM) ? STEP_LIM : dn_dist);
   end

   always_comb begin
      state_nxt = state;
      tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
      hold_done = (hold_cnt == HW'(HOLD_CYC - 1));
      case (state)
         S_IDLE:  if (dirty || tgt != CUR_CODE) state_nxt = S_STEP;
         S_STEP:  state_nxt = S_REQ;
         S_REQ:   if (tmo_hit)        state_nxt = S_FAULT;
                  else if (!spi.OVER) state_nxt = S_XFER;
         // Timeout wins over a completion seen on the same edge.
         S_XFER:  if (tmo_hit)        state_nxt = S_FAULT;
                  else if (spi.OVER)  state_nxt = (HOLD_CYC == 0) ? S_IDLE : S_HOLD;
         S_HOLD:  if (hold_done) state_nxt = S_IDLE;
         S_FAULT: if (CLR_ERR)   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= S_IDLE;
         tr_q        <= 1'b0;
         data_q      <= INIT_WORD;
         CUR_CODE    <= INIT_CODE;
         tgt         <= INIT_CODE;
         dirty       <= 1'b1;
         ERR_TIMEOUT <= 1'b0;
         tmo_cnt     <= '0;
         hold_cnt    <= '0;
      end else begin
         state <= state_nxt;
         tr_q  <= (state_nxt == S_REQ);
         if (TGT_VALID) tgt <= TGT_CODE;
         case (state)
            S_STEP: begin
               data_q  <= {6'b0, PD_MODE, next_code};
               dirty   <= 1'b0;
               tmo_cnt <= '0;
            end
            S_REQ, S_XFER: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (state_nxt == S_FAULT)
                  ERR_TIMEOUT <= 1'b1;
               else if (state == S_XFER && spi.OVER) begin
                  CUR_CODE <= data_q[15:0];
                  hold_cnt <= '0;
               end
            end
            S_HOLD:  hold_cnt <= hold_cnt + 1'b1;
            // Setting dirty makes IDLE retry the failed step even if already on target.
            S_FAULT: if (CLR_ERR) begin
               ERR_TIMEOUT <= 1'b0;
               dirty       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign spi.TR    = tr_q;
   assign spi.DATA  = data_q;
   assign BUSY      = (state != S_IDLE);
   assign AT_TARGET = (state == S_IDLE) && !dirty && (CUR_CODE == tgt);
endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Directed bench for dac_ramp_ctrl: behavioural SPI engine plus a code-level model
// of the ramp, checked every cycle, with literal expectations for each scenario.
module tb_dac_ramp_ctrl;
   localparam int          MAX_STEP    = 256;
   localparam int          HOLD_CYC    = 10;
   localparam int          TIMEOUT_CYC = 4096;
   localparam int          XFER_CYC    = 50;
   localparam logic [15:0] INIT        = 16'h8000;

   logic        CLK = 1'b0, RESET = 1'b1, TGT_VALID = 1'b0, CLR_ERR = 1'b0;
   logic [15:0] TGT_CODE = '0;
   logic [15:0] CUR_CODE, pd_cur;
   logic        BUSY, AT_TARGET, ERR_TIMEOUT, pd_busy, pd_at, pd_err;
   logic        over_r = 1'b1, stall = 1'b0;

   dac_ramp_ctrl_if sif ();
   dac_ramp_ctrl_if pif ();
   assign sif.OVER = over_r;
   assign pif.OVER = 1'b1;

   always #5 CLK = ~CLK;

   dac_ramp_ctrl #(.MAX_STEP(MAX_STEP), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
                   .INIT_CODE(INIT), .PD_MODE(2'b00)) u_dut (
      .CLK(CLK), .RESET(RESET), .TGT_VALID(TGT_VALID), .TGT_CODE(TGT_CODE),
      .CLR_ERR(CLR_ERR), .spi(sif), .CUR_CODE(CUR_CODE), .BUSY(BUSY),
      .AT_TARGET(AT_TARGET), .ERR_TIMEOUT(ERR_TIMEOUT));

   // Second instance only pins the DATA word layout for a non-zero PD_MODE.
   dac_ramp_ctrl #(.INIT_CODE(16'h1234), .PD_MODE(2'b01)) u_pd (
      .CLK(CLK), .RESET(RESET), .TGT_VALID(1'b0), .TGT_CODE(16'h0000),
      .CLR_ERR(1'b0), .spi(pif), .CUR_CODE(pd_cur), .BUSY(pd_busy),
      .AT_TARGET(pd_at), .ERR_TIMEOUT(pd_err));

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] step_to(input logic [15:0] c, input logic [15:0] t);
      int d;
      d = int'(t) - int'(c);
      if (d > MAX_STEP) d = MAX_STEP;
      else if (d < -MAX_STEP) d = -MAX_STEP;
      return 16'(int'(c) + d);
   endfunction

   // Engine + model: code written so far, the requested target, and accepted words.
   logic [15:0] mcur, mtgt;
   logic [23:0] lat;
   logic [23:0] wr_q[$];
   int          xcnt, gap;
   bit          pend, gap_ok;

   always @(negedge CLK) begin
      if (RESET) begin
         over_r = 1'b1; pend = 1'b0; gap_ok = 1'b0; gap = 0; xcnt = 0;
         mcur = INIT; mtgt = INIT;
      end else begin
         if (pend) begin mcur = lat[15:0]; pend = 1'b0; end
         chk("cur_code", CUR_CODE, mcur);
         if (AT_TARGET === 1'b1) chk("at_target_code", CUR_CODE, mtgt);
         if (!over_r) chk("data_hold", sif.DATA, lat);
         if (over_r && sif.TR === 1'b1 && !stall) begin
            chk("step_word", sif.DATA, {8'h00, step_to(mcur, mtgt)});
            if (gap_ok) chk("hold_gap", gap >= HOLD_CYC, 1);
            gap_ok = 1'b0;
            lat = sif.DATA; wr_q.push_back(sif.DATA); over_r = 1'b0; xcnt = XFER_CYC;
         end else if (!over_r) begin
            xcnt--;
            if (xcnt == 0) begin over_r = 1'b1; pend = 1'b1; gap = 0; gap_ok = 1'b1; end
         end else if (sif.TR !== 1'b1) gap++;
         if (TGT_VALID) mtgt = TGT_CODE;
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic set_tgt(input logic [15:0] c);
      tick(); TGT_VALID = 1'b1; TGT_CODE = c;
      tick(); TGT_VALID = 1'b0;
   endtask

   task automatic pulse_clr();
      tick(); CLR_ERR = 1'b1;
      tick(); CLR_ERR = 1'b0;
   endtask

   task automatic wait_at(input int lim, input string name);
      int n;
      n = 0;
      while (AT_TARGET !== 1'b1 && n < lim) begin tick(); n++; end
      chk({name, "_settled"}, AT_TARGET, 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      RESET = 1'b1;
      repeat (3) tick();
      chk("rst_tr", sif.TR, 0);
      chk("rst_data", sif.DATA, 24'h008000);
      chk("rst_cur", CUR_CODE, 16'h8000);
      chk("rst_busy", BUSY, 0);
      chk("rst_err", ERR_TIMEOUT, 0);
      chk("rst_at", AT_TARGET, 0);
      chk("pd_rst_data", pif.DATA, 24'h011234);
      RESET = 1'b0;
      repeat (3) tick();
      chk("pd_tr", pif.TR, 1);
      chk("pd_data", pif.DATA, 24'h011234);

      wait_at(300, "init");
      chk("init_writes", wr_q.size(), 1);
      chk("init_word", wr_q[0], 24'h008000);
      chk("init_cur", CUR_CODE, 16'h8000);

      pulse_clr();
      repeat (2) tick();
      chk("clr_idle_at", AT_TARGET, 1);
      chk("clr_idle_busy", BUSY, 0);

      base = wr_q.size();
      set_tgt(16'h8300);
      wait_at(1000, "up");
      chk("up_n", wr_q.size(), base + 3);
      chk("up_0", wr_q[base], 24'h008100);
      chk("up_1", wr_q[base+1], 24'h008200);
      chk("up_2", wr_q[base+2], 24'h008300);

      base = wr_q.size();
      set_tgt(16'h8000);
      wait_at(1000, "down");
      chk("down_n", wr_q.size(), base + 3);
      chk("down_2", wr_q[base+2], 24'h008000);

      base = wr_q.size();
      set_tgt(16'h9000);
      n = 0;
      while (!(wr_q.size() == base + 2 && !over_r) && n < 1000) begin tick(); n++; end
      chk("rt_in_xfer", wr_q.size(), base + 2);
      set_tgt(16'h8000);
      wait_at(1000, "rt");
      chk("rt_n", wr_q.size(), base + 4);
      chk("rt_0", wr_q[base], 24'h008100);
      chk("rt_1", wr_q[base+1], 24'h008200);
      chk("rt_2", wr_q[base+2], 24'h008100);
      chk("rt_3", wr_q[base+3], 24'h008000);

      base = wr_q.size();
      set_tgt(16'h7F80);
      wait_at(1000, "part");
      chk("part_n", wr_q.size(), base + 1);
      chk("part_0", wr_q[base], 24'h007F80);

      base = wr_q.size();
      set_tgt(16'h0000);
      wait_at(12000, "zero");
      chk("zero_n", wr_q.size(), base + 128);
      chk("zero_pen", wr_q[base+126], 24'h000080);
      chk("zero_last", wr_q[base+127], 24'h000000);
      chk("zero_cur", CUR_CODE, 16'h0000);

      stall = 1'b1;
      set_tgt(16'h0100);
      n = 0;
      while (sif.TR !== 1'b1 && n < 100) begin tick(); n++; end
      chk("to_req", sif.TR, 1);
      n = 0;
      while (sif.TR === 1'b1 && n < 5000) begin tick(); n++; end
      chk("to_len", n, TIMEOUT_CYC);
      chk("to_err", ERR_TIMEOUT, 1);
      chk("to_cur", CUR_CODE, 16'h0000);
      chk("to_busy", BUSY, 1);
      repeat (5) tick();
      chk("to_fault_tr", sif.TR, 0);
      chk("to_sticky", ERR_TIMEOUT, 1);
      stall = 1'b0;
      pulse_clr();
      chk("to_clr", ERR_TIMEOUT, 0);
      wait_at(500, "retry");
      chk("retry_word", wr_q[wr_q.size()-1], 24'h000100);
      chk("retry_cur", CUR_CODE, 16'h0100);

      base = wr_q.size();
      set_tgt(16'h0300);
      n = 0;
      while (over_r && n < 200) begin tick(); n++; end
      chk("rx_in_xfer", wr_q.size(), base + 1);
      RESET = 1'b1;
      tick();
      chk("rx_tr", sif.TR, 0);
      chk("rx_cur", CUR_CODE, 16'h8000);
      chk("rx_data", sif.DATA, 24'h008000);
      chk("rx_busy", BUSY, 0);
      RESET = 1'b0;
      wait_at(300, "rx");
      chk("rx_word", wr_q[wr_q.size()-1], 24'h008000);
      chk("rx_final", CUR_CODE, 16'h8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
